// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO between the character pipeline and the UART
// transmitter. Drains one byte per single-cycle strobe, paced by tx_busy,
// with a bounded wait for the UART to acknowledge each strobe.
module uart_tx_queue #(
  parameter int DEPTH_LOG2    = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_byte,
  input  logic                  clear_overflow,
  input  logic                  tx_busy,
  output logic                  tx_transmit,
  output logic [7:0]            tx_byte,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  // Wide enough to hold START_TIMEOUT itself, never zero bits.
  localparam int TW    = $clog2(START_TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

  state_t                  state;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [TW-1:0]           tmo_cnt;
  logic                    push;
  logic                    pop;
  logic [CW-1:0]           count_nxt;

  // Acceptance uses the registered full flag, so a pop on the same edge
  // does not make room for a write; the head is popped on the LAUNCH edge.
  always_comb begin
    push      = wr_en && !full;
    pop       = (state == LAUNCH);
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage array; contents are not reset, the pointers define validity.
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= wr_byte;
  end

  // Pointers, occupancy, status flags and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      // A dropped write wins over a simultaneous clear.
      if (wr_en && full)       overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Transmit sequencer: launch, wait for the UART to go busy (bounded),
  // then wait for it to finish before the next launch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tx_transmit <= 1'b0;
      tx_byte     <= 8'h00;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_transmit <= 1'b0;
          if (!empty && !tx_busy) state <= LAUNCH;
        end
        LAUNCH: begin
          tx_byte     <= mem[rd_ptr];
          tx_transmit <= 1'b1;
          tmo_cnt     <= '0;
          state       <= WAIT_START;
        end
        WAIT_START: begin
          tx_transmit <= 1'b0;
          if (tx_busy) begin
            tmo_cnt <= '0;
            state   <= WAIT_DONE;
          end else if (tmo_cnt == TW'(START_TIMEOUT)) begin
            // UART never acknowledged: treat the byte as sent.
            tmo_cnt <= '0;
            state   <= IDLE;
          end else if (!tx_transmit) begin
            // The window opens once the UART has had its edge to sample
            // the strobe, so the strobe cycle itself is not counted.
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          tx_transmit <= 1'b0;
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: a scoreboard queue holds bytes the bench
// expects the DUT to accept, and every transmit strobe pops and compares.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int TMO   = 4;
  localparam int BUSY  = 313 * 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       clear_overflow = 1'b0;
  logic       busy_force = 1'b0;
  logic       uart_mode = 1'b0;
  logic       tx_busy;
  logic       tx_transmit;
  logic [7:0] tx_byte;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;

  uart_tx_queue #(.DEPTH_LOG2(4), .START_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_byte(wr_byte),
    .clear_overflow(clear_overflow), .tx_busy(tx_busy),
    .tx_transmit(tx_transmit), .tx_byte(tx_byte), .full(full),
    .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // UART model: goes busy the edge after a strobe and stays busy BUSY cycles.
  int ubusy = 0;
  always @(posedge clock) begin
    if (uart_mode && tx_transmit) ubusy <= BUSY;
    else if (ubusy != 0)          ubusy <= ubusy - 1;
  end
  assign tx_busy = uart_mode ? (ubusy != 0) : busy_force;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb [$];
  int         strobe_n = 0;
  int         last_strobe = 0;
  int         prev_strobe = 0;
  logic       prev_tx = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: pop/compare scoreboard, spacing and busy rules.
  always @(negedge clock) begin
    if (tx_transmit) begin
      chk("strobe_back_to_back", 32'(prev_tx), 32'd0);
      if (uart_mode) chk("strobe_while_busy", 32'(tx_busy), 32'd0);
      chk("strobe_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk("tx_byte_order", 32'(tx_byte), 32'(sb.pop_front()));
      prev_strobe = last_strobe;
      last_strobe = cyc;
      strobe_n++;
    end
    prev_tx = tx_transmit;
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_byte = b;
    if (sb.size() < DEPTH) sb.push_back(b);
    tick;
    wr_en = 1'b0;
  endtask

  task automatic wait_strobes(input string tag, input int n, input int budget);
    int t = 0;
    while (strobe_n < n && t < budget) begin
      tick;
      t++;
    end
    chk(tag, 32'(strobe_n), 32'(n));
  endtask

  initial begin
    int n0;
    int s0;

    // Reset state
    tick; tick;
    reset = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_transmit", 32'(tx_transmit), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    tick;

    // 1: single byte, latency to strobe
    busy_force = 1'b0;
    wr(8'h41);
    n0 = cyc;
    chk("t1_empty_fall", 32'(empty), 32'd0);
    chk("t1_count1", 32'(count), 32'd1);
    tick;
    chk("t1_no_strobe_yet", 32'(tx_transmit), 32'd0);
    tick;
    chk("t1_strobe", 32'(tx_transmit), 32'd1);
    chk("t1_tx_byte", 32'(tx_byte), 32'h41);
    chk("t1_latency", 32'(last_strobe), 32'(n0 + 2));
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    tick;
    chk("t1_strobe_one_cycle", 32'(tx_transmit), 32'd0);
    repeat (10) tick;

    // 2: burst of 20 while busy, overflow, ordered drain
    busy_force = 1'b1;
    for (int i = 0; i < 20; i++) wr(8'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count16", 32'(count), 32'd16);
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_not_empty", 32'(empty), 32'd0);
    s0 = strobe_n;
    busy_force = 1'b0;
    wait_strobes("t2_drain_strobes", s0 + 16, 400);
    chk("t2_sb_drained", 32'(sb.size()), 32'd0);
    chk("t2_empty", 32'(empty), 32'd1);
    repeat (10) tick;
    clear_overflow = 1'b1;
    tick;
    clear_overflow = 1'b0;
    chk("t2_overflow_cleared", 32'(overflow), 32'd0);

    // 4: timeout pacing with busy tied low
    s0 = strobe_n;
    wr(8'hA0);
    wr(8'hA1);
    wait_strobes("t4_strobes", s0 + 2, 60);
    chk("t4_spacing", 32'(last_strobe - prev_strobe), 32'(4 + TMO));
    chk("t4_empty", 32'(empty), 32'd1);
    repeat (10) tick;

    // 3: busy handshake with the UART model
    uart_mode = 1'b1;
    s0 = strobe_n;
    wr(8'hB0);
    wr(8'hB1);
    wr(8'hB2);
    wait_strobes("t3_first", s0 + 1, 20);
    wait_strobes("t3_second", s0 + 2, BUSY + 50);
    chk("t3_gap2", 32'(last_strobe - prev_strobe), 32'(BUSY + 4));
    wait_strobes("t3_third", s0 + 3, BUSY + 50);
    chk("t3_gap3", 32'(last_strobe - prev_strobe), 32'(BUSY + 4));
    repeat (BUSY + 10) tick;
    chk("t3_empty", 32'(empty), 32'd1);

    // 5: reset with 5 queued and 1 in flight
    s0 = strobe_n;
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
    chk("t5_inflight", 32'(strobe_n), 32'(s0 + 1));
    chk("t5_count5", 32'(count), 32'd5);
    reset = 1'b1;
    sb.delete();
    tick;
    reset = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_full", 32'(full), 32'd0);
    chk("t5_tx_transmit", 32'(tx_transmit), 32'd0);
    chk("t5_overflow", 32'(overflow), 32'd0);
    chk("t5_tx_byte", 32'(tx_byte), 32'h00);
    s0 = strobe_n;
    repeat (50) tick;
    chk("t5_no_strobes", 32'(strobe_n), 32'(s0));
    uart_mode = 1'b0;
    busy_force = 1'b0;

    // 6: write on the LAUNCH edge of a full FIFO is dropped
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'hD0 + 8'(i));
    chk("t6_full", 32'(full), 32'd1);
    busy_force = 1'b0;
    tick;
    busy_force = 1'b1;
    wr(8'hEE);
    chk("t6_strobe", 32'(tx_transmit), 32'd1);
    chk("t6_count15", 32'(count), 32'd15);
    chk("t6_overflow", 32'(overflow), 32'd1);
    chk("t6_not_full", 32'(full), 32'd0);
    clear_overflow = 1'b1;
    tick;
    clear_overflow = 1'b0;
    chk("t6_overflow_cleared", 32'(overflow), 32'd0);
    chk("t6_count_hold", 32'(count), 32'd15);
    wr(8'hEF);
    chk("t6_refull", 32'(full), 32'd1);
    clear_overflow = 1'b1;
    wr(8'hF0);
    clear_overflow = 1'b0;
    chk("t6_drop_beats_clear", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick;
    clear_overflow = 1'b0;
    chk("t6_overflow_cleared2", 32'(overflow), 32'd0);
    s0 = strobe_n;
    busy_force = 1'b0;
    wait_strobes("t6_drain_strobes", s0 + 16, 400);
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    repeat (10) tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
